// File: rtl/id_stage_ctrl_if.sv
// Decode-stage handshake bundle: fetch side, execute side and the decoded class strobes.
// The master drives fetch/EX inputs; the slave is the decode-stage controller.
interface id_stage_ctrl_if #(
    parameter int unsigned XLEN = 64
);
    logic            if_valid;
    logic [31:0]     if_instruction;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;
    logic            flush;
    logic            ex_ready;
    logic            ex_valid;
    logic            ex_is_load;
    logic [4:0]      ex_rd;
    logic            id_valid;
    logic [31:0]     id_instruction;
    logic [XLEN-1:0] id_pc;
    logic            r_type;
    logic            i_type;
    logic            l_type;
    logic            s_type;
    logic            b_type;
    logic            j_type;
    logic            u_type;
    logic            id_illegal;
    logic [31:0]     stall_cnt;

    modport master (
        output if_valid, if_instruction, if_pc, flush, ex_ready, ex_valid, ex_is_load, ex_rd,
        input  if_ready, id_valid, id_instruction, id_pc,
        input  r_type, i_type, l_type, s_type, b_type, j_type, u_type, id_illegal, stall_cnt
    );

    modport slave (
        input  if_valid, if_instruction, if_pc, flush, ex_ready, ex_valid, ex_is_load, ex_rd,
        output if_ready, id_valid, id_instruction, id_pc,
        output r_type, i_type, l_type, s_type, b_type, j_type, u_type, id_illegal, stall_cnt
    );
endinterface

// File: rtl/id_stage_ctrl.sv
// RV64 decode-stage controller: IF/ID register, opcode classification, load-use bubble, flush.
// Optional load-use stall counter enabled by defining ID_STALL_CNT_EN.
module id_stage_ctrl #(
    parameter int unsigned XLEN = 64
) (
    input  logic          clk,
    input  logic          rst,
    id_stage_ctrl_if.slave bus
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_RW   = 7'b0111011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_IW   = 7'b0011011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE= 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUIPC= 7'b0010111;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;

    logic       w_full;
    logic [6:0] w_opcode;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_r, w_i, w_l, w_s, w_b, w_j, w_u, w_illegal;
    logic       w_rs1_used;
    logic       w_rs2_used;
    logic       w_hazard;
    logic       w_id_valid;
    logic       w_fire;

    assign w_full   = (r_state == S_FULL);
    assign w_opcode = r_instr[6:0];
    assign w_rs1    = r_instr[19:15];
    assign w_rs2    = r_instr[24:20];

    // Class strobes are only meaningful while an instruction is held.
    always_comb begin
        w_r       = 1'b0;
        w_i       = 1'b0;
        w_l       = 1'b0;
        w_s       = 1'b0;
        w_b       = 1'b0;
        w_j       = 1'b0;
        w_u       = 1'b0;
        w_illegal = 1'b0;
        if (w_full) begin
            case (w_opcode)
                OP_R, OP_RW:      w_r = 1'b1;
                OP_I, OP_IW:      w_i = 1'b1;
                OP_LOAD:          w_l = 1'b1;
                OP_STORE:         w_s = 1'b1;
                OP_BR:            w_b = 1'b1;
                OP_JAL, OP_JALR:  w_j = 1'b1;
                OP_LUI, OP_AUIPC: w_u = 1'b1;
                default:          w_illegal = 1'b1;
            endcase
        end
    end

    assign w_rs1_used = w_r | w_i | w_l | w_s | w_b | (w_j & (w_opcode == OP_JALR));
    assign w_rs2_used = w_r | w_s | w_b;

    assign w_hazard = w_full & bus.ex_valid & bus.ex_is_load & (bus.ex_rd != 5'd0) &
                      ((w_rs1_used & (w_rs1 == bus.ex_rd)) | (w_rs2_used & (w_rs2 == bus.ex_rd)));

    assign w_id_valid = w_full & ~w_hazard & ~bus.flush;
    assign w_fire     = w_id_valid & bus.ex_ready;

    assign bus.if_ready       = ~w_full | w_fire;
    assign bus.id_valid       = w_id_valid;
    assign bus.id_instruction = r_instr;
    assign bus.id_pc          = r_pc;
    assign bus.r_type         = w_r;
    assign bus.i_type         = w_i;
    assign bus.l_type         = w_l;
    assign bus.s_type         = w_s;
    assign bus.b_type         = w_b;
    assign bus.j_type         = w_j;
    assign bus.u_type         = w_u;
    assign bus.id_illegal     = w_illegal;

    // IF/ID register and occupancy; flush wins over any load in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_instr <= 32'd0;
            r_pc    <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (bus.if_valid && !bus.flush) begin
                        r_state <= S_FULL;
                        r_instr <= bus.if_instruction;
                        r_pc    <= bus.if_pc;
                    end
                end
                S_FULL: begin
                    if (bus.flush) begin
                        r_state <= S_EMPTY;
                        r_instr <= 32'd0;
                        r_pc    <= '0;
                    end else if (w_fire) begin
                        if (bus.if_valid) begin
                            r_instr <= bus.if_instruction;
                            r_pc    <= bus.if_pc;
                        end else begin
                            r_state <= S_EMPTY;
                        end
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

`ifdef ID_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Counts bubble cycles; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (w_full && w_hazard && !bus.flush) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = 32'd0;
`endif

endmodule

// File: doc/id_stage_ctrl.md
Name: id_stage_ctrl

Overview:
- Controls the decode stage of the five-stage RV64 pipeline: owns the IF/ID pipeline register, classifies the held instruction into the one-hot type strobes that configure the immediate-extension unit, and sequences stalls.
- Provides a valid/ready handshake to fetch and to execute, inserts a one-cycle bubble on load-use hazards, and clears on branch/jump flush.

Parameters:
- XLEN, 64, PC width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- if_valid  in  1  fetch presents an instruction.
- if_instruction  in  32  fetched instruction.
- if_pc  in  XLEN  PC of the fetched instruction.
- if_ready  out  1  decode can accept this cycle.
- flush  in  1  redirect from EX; kills the held instruction.
- ex_ready  in  1  EX accepts this cycle.
- ex_valid  in  1  EX holds a valid instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- id_valid  out  1  decode presents an instruction to EX.
- id_instruction  out  32  held instruction.
- id_pc  out  XLEN  held PC.
- r_type, i_type, l_type, s_type, b_type, j_type, u_type  out  1 each  one-hot class of the held instruction.
- id_illegal  out  1  held opcode is not in any class.
- stall_cnt  out  32  load-use stall cycles (only with the optional feature).

Behaviour:
- Reset (async, immediate): state EMPTY; id_instruction = 0, id_pc = 0, all type strobes = 0, id_illegal = 0, id_valid = 0, stall_cnt = 0.
- Classification is combinational from the registered id_instruction[6:0] and is valid only in state FULL (0 otherwise):
  - R: 0110011, 0111011
  - I: 0010011, 0011011
  - L: 0000011
  - S: 0100011
  - B: 1100011
  - J: 1101111 (jal), 1100111 (jalr)
  - U: 0110111, 0010111
  - Any other opcode: id_illegal = 1, all strobes = 0.
- rs1 is used by R, I, L, S, B and jalr. rs2 is used by R, S and B.
- hazard = FULL & ex_valid & ex_is_load & (ex_rd != 0) & ((rs1 used & rs1 == ex_rd) | (rs2 used & rs2 == ex_rd)).
- id_valid = FULL & ~hazard & ~flush.
- fire_out = id_valid & ex_ready.
- if_ready = EMPTY | fire_out. This is combinational and must not depend on if_valid.
- FSM states: EMPTY, FULL.
  - EMPTY: if_valid & ~flush → load the register, go to FULL. Otherwise stay.
  - FULL: flush → EMPTY (register cleared to 0). Otherwise fire_out & if_valid → reload, stay FULL (back-to-back, 1 instruction per cycle). fire_out & ~if_valid → EMPTY. Otherwise hold; instruction and PC remain unchanged.
- flush has priority over every other event, including a simultaneous if_valid; the fetched instruction that cycle is discarded.
- Hazard produces exactly one bubble per matching load: EX receives no instruction, so the next cycle ex_valid/ex_is_load reflect the bubble and the held instruction issues.
- Latency: an accepted if_instruction appears on id_instruction the next cycle. Throughput is 1 per cycle with no hazard.
- Illegal instructions still pass to EX with id_illegal = 1; trap handling is outside this block.
- A held instruction is never modified while FULL and not fired.

Optional Feature:
- Macro: ID_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on every cycle where FULL & hazard & ~flush. It wraps at 2^32-1 → 0 and is cleared only by rst.
- Undefined: no counter register is built; the stall_cnt port still exists and is tied to 0.

Test Plan:
- Stream: if_valid = 1 every cycle with addi x1,x0,5 (0x00500093) then sw x1,0(x2) (0x00112023), ex_ready = 1.
  - id_valid is 1 from cycle 1.
  - i_type = 1, then s_type = 1 on the following cycle.
  - if_ready stays 1 throughout.
- Backpressure: FULL with lui (0x000012B7), ex_ready = 0 for 3 cycles.
  - u_type = 1 and id_instruction is stable throughout.
  - if_ready = 0 during backpressure.
  - The new instruction loads the cycle after ex_ready returns to 1.
- Load-use: hold add x3,x1,x2 (0x002081B3) with ex_valid = 1, ex_is_load = 1, ex_rd = 1.
  - id_valid = 0 for one cycle, then 1 once ex_valid = 0.
  - stall_cnt = 1 with ID_STALL_CNT_EN defined.
- No false hazard: same setup with ex_rd = 0, and separately lui x5 held with ex_rd = 5.
  - No bubble; id_valid = 1 immediately.
- Flush: flush = 1 while FULL with jal (0x0000006F) and if_valid = 1 in the same cycle.
  - Next cycle EMPTY: id_valid = 0, all strobes 0, id_instruction = 0.
- Illegal/reset: hold opcode 0x0000007F.
  - id_illegal = 1, all strobes 0, id_valid = 1.
  - Assert rst mid-cycle: all outputs go to 0 immediately, without waiting for a clock edge.
